// File: rtl/tap_crossfader_pkg.sv
// Shared types and helpers for the tap crossfader.
//   state_e  : FSM state encoding (IDLE / FADE).
//   map_sel  : folds every out-of-range select code onto the single mute code.
package tap_crossfader_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_e;

  // The mute code equals the tap count, so it is the first code with no tap behind it.
  function automatic logic [7:0] mute_code(input int unsigned ntaps);
    return 8'(ntaps);
  endfunction

  // Codes below the tap count pass through; every other code collapses to the mute code.
  function automatic logic [7:0] map_sel(input logic [7:0] code, input int unsigned ntaps);
    return (code < mute_code(ntaps)) ? code : mute_code(ntaps);
  endfunction

endpackage

// File: rtl/crossfade_mix.sv
// Combinational linear blend of two unsigned samples.
//   a  : outgoing sample (weight N-k)
//   b  : incoming sample (weight k)
//   k  : blend step, 0..N where N = 2**FADE_LOG2
//   y  : (a*(N-k) + b*k) >> FADE_LOG2, truncated
module crossfade_mix #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FADE_LOG2 = 3
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [FADE_LOG2:0] k,
  output logic [WIDTH-1:0]   y
);

  localparam int unsigned PW = WIDTH + FADE_LOG2 + 1;
  localparam logic [PW-1:0] N_P = PW'(1) << FADE_LOG2;

  logic [PW-1:0] wk;
  logic [PW-1:0] prod_a;
  logic [PW-1:0] prod_b;
  logic [PW-1:0] sum;

  always_comb begin
    wk     = PW'(k);
    prod_a = PW'(a) * (N_P - wk);
    prod_b = PW'(b) * wk;
    // Sum never exceeds (2**WIDTH-1)*N, so the shifted value always fits WIDTH bits.
    sum    = prod_a + prod_b;
    y      = WIDTH'(sum >> FADE_LOG2);
  end

endmodule

// File: rtl/tap_crossfader.sv
// Tap selector with a linear crossfade on every change of the selected source.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   sample_en : sample strobe; output and fade advance only when high
//   taps      : packed tap outputs, tap k at [k*WIDTH +: WIDTH]
//   sel       : 8-bit select code; codes >= NTAPS mute (source value 0)
//   y         : registered output sample
//   busy      : high while a crossfade is in progress
module tap_crossfader
  import tap_crossfader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NTAPS     = 4,
  parameter int unsigned FADE_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic [NTAPS*WIDTH-1:0] taps,
  input  logic [7:0]             sel,
  output logic [WIDTH-1:0]       y,
  output logic                   busy
);

  localparam logic [7:0]         MUTE_CODE = mute_code(NTAPS);
  localparam logic [FADE_LOG2:0] N_STEPS   = (FADE_LOG2+1)'(1) << FADE_LOG2;

  state_e                 state_q, state_d;
  logic [7:0]             cur_q, cur_d;
  logic [7:0]             nxt_q, nxt_d;
  logic [FADE_LOG2:0]     k_q, k_d;
  logic [WIDTH-1:0]       y_q, y_d;

  logic [WIDTH-1:0]       tap_arr [NTAPS];
  logic [WIDTH-1:0]       src_cur;
  logic [WIDTH-1:0]       src_nxt;
  logic [7:0]             sel_mapped;
  logic [FADE_LOG2:0]     k_step;
  logic [WIDTH-1:0]       mix_y;

  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    assign tap_arr[i] = taps[i*WIDTH +: WIDTH];
  end

  // Source lookup; the mute code matches no tap and so reads as 0.
  always_comb begin
    src_cur = '0;
    src_nxt = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (cur_q == 8'(i)) src_cur = tap_arr[i];
      if (nxt_q == 8'(i)) src_nxt = tap_arr[i];
    end
  end

  assign sel_mapped = map_sel(sel, NTAPS);
  assign k_step     = k_q + 1'b1;

  crossfade_mix #(
    .WIDTH     (WIDTH),
    .FADE_LOG2 (FADE_LOG2)
  ) u_mix (
    .a (src_cur),
    .b (src_nxt),
    .k (k_step),
    .y (mix_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      k_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      k_q     <= k_d;
      y_q     <= y_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    k_d     = k_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (sample_en) y_d = src_cur;
        // Fade entry does not wait for the strobe; only the steps do.
        if (sel_mapped != cur_q) begin
          nxt_d   = sel_mapped;
          k_d     = '0;
          state_d = FADE;
        end
      end
      FADE: begin
        // sel is ignored here; it is re-compared once back in IDLE.
        if (sample_en) begin
          y_d = mix_y;
          k_d = k_step;
          if (k_step == N_STEPS) begin
            cur_d   = nxt_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    y    = y_q;
    busy = (state_q == FADE);
  end

  // MUTE_CODE is the value nxt/cur hold for a muted source.
  logic unused_mute;
  assign unused_mute = ^MUTE_CODE;

endmodule

// File: tb/tb_tap_crossfader.sv
// Directed bench for tap_crossfader with hand-computed expected samples.
module tb_tap_crossfader;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [31:0] taps;
  logic [7:0]  sel;
  logic [7:0]  y;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tap_crossfader #(
    .WIDTH     (8),
    .NTAPS     (4),
    .FADE_LOG2 (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .taps      (taps),
    .sel       (sel),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp_up [8];
    logic [7:0] exp_mute [8];
    exp_up   = '{8'h48, 8'h50, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h80};
    exp_mute = '{8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00};

    taps      = {8'hFF, 8'hC0, 8'h80, 8'h40};
    sel       = 8'd1;
    sample_en = 1'b1;
    rst       = 1'b1;

    // Reset with sel=1 held
    tick();
    check("rst_y0", y, 0);
    check("rst_busy0", busy, 0);
    tick();
    check("rst_y1", y, 0);
    check("rst_busy1", busy, 0);
    rst = 1'b0;

    // Fade 0 -> 1 starts one clock after release
    tick();
    check("entry_busy", busy, 1);
    check("entry_y", y, 8'h40);
    for (int s = 0; s < 8; s++) begin
      tick();
      check($sformatf("fade01_y%0d", s), y, exp_up[s]);
      check($sformatf("fade01_busy%0d", s), busy, (s < 7) ? 1 : 0);
    end
    tick();
    check("fade01_hold", y, 8'h80);
    check("fade01_idle", busy, 0);

    // Move to tap3, then fade to mute
    sel = 8'd3;
    tick();
    wait_idle();
    check("tap3_y", y, 8'hFF);
    sel = 8'h07;
    tick();
    check("mute_entry", busy, 1);
    for (int s = 0; s < 8; s++) begin
      tick();
      check($sformatf("mute_y%0d", s), y, exp_mute[s]);
    end
    sel = 8'h55;
    tick();
    tick();
    check("mute_alias_busy", busy, 0);
    check("mute_alias_y", y, 0);

    // Gated strobe: fade 0 -> 2 with sample_en every third clock
    sel = 8'd0;
    tick();
    wait_idle();
    check("tap0_y", y, 8'h40);
    sel       = 8'd2;
    sample_en = 1'b0;
    tick();
    check("gate_entry_busy", busy, 1);
    check("gate_entry_y", y, 8'h40);
    for (int c = 1; c <= 24; c++) begin
      sample_en = (c % 3 == 0);
      tick();
      check($sformatf("gate_y%0d", c), y, 8'h40 + 8'h10 * (c / 3));
      check($sformatf("gate_busy%0d", c), busy, (c < 24) ? 1 : 0);
    end
    sample_en = 1'b1;

    // sel change during fade is deferred to the next IDLE compare
    sel = 8'd0;
    tick();
    wait_idle();
    sel = 8'd1;
    tick();
    check("chg_entry", busy, 1);
    for (int s = 0; s < 3; s++) tick();
    check("chg_step3", y, 8'h58);
    sel = 8'd3;
    for (int s = 0; s < 5; s++) tick();
    check("chg_done_y", y, 8'h80);
    check("chg_done_busy", busy, 0);
    tick();
    check("chg_refade_busy", busy, 1);
    check("chg_refade_hold", y, 8'h80);
    tick();
    check("chg_refade_step1", y, 8'h8F);
    wait_idle();
    check("chg_tap3_y", y, 8'hFF);

    // Toggle to 3 and back mid-fade: only one fade
    sel = 8'd1;
    tick();
    check("tog_entry", busy, 1);
    tick();
    sel = 8'd3;
    tick();
    sel = 8'd1;
    tick();
    wait_idle();
    tick();
    tick();
    check("tog_no_refade", busy, 0);
    check("tog_y", y, 8'h80);

    // Reset in the middle of fade 0 -> 3
    sel = 8'd0;
    tick();
    wait_idle();
    sel = 8'd3;
    tick();
    for (int s = 0; s < 4; s++) tick();
    check("rmid_step4", y, 8'h9F);
    rst = 1'b1;
    sel = 8'd0;
    tick();
    check("rmid_y", y, 0);
    check("rmid_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("rmid_post_y", y, 8'h40);
    check("rmid_post_busy", busy, 0);
    tick();
    check("rmid_no_fade", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_crossfader.md
# tap_crossfader

Downstream selector for the multi-tap delay-line bank. It receives the bank's fixed-length tap outputs and drives the 8-bit output sample, using the tap chosen by a select code. The plain combinational tap mux switches abruptly; this block instead performs a linear crossfade from the old tap to the new tap whenever the selection changes. A select code with no matching tap acts as a mute source, with value 0.

## Interface
Parameters:
- WIDTH, 8, sample width in bits (unsigned).
- NTAPS, 4, number of delay taps presented.
- FADE_LOG2, 3, log2 of crossfade length in samples (N = 2**FADE_LOG2 = 8).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  sample strobe; output and fade advance only when high. Tie to 1 for per-clock operation.
- taps  input  NTAPS*WIDTH  tap k occupies bits [k*WIDTH +: WIDTH]; tap 0 is the shortest delay.
- sel  input  8  tap select code. Values 0..NTAPS-1 pick a tap; any other value selects MUTE.
- y  output  WIDTH  registered output sample.
- busy  output  1  high while a crossfade is in progress.

## Operation
- Source mapping: src(s) = taps[s] if s < NTAPS, else 0 (MUTE).
  - sel is compared as a full 8-bit code.
  - All MUTE codes are equivalent; they are stored as the single internal code NTAPS.
- State registers:
  - cur: active source.
  - nxt: fade target.
  - k: fade step, FADE_LOG2+1 bits.
  - state.
- IDLE:
  - If sample_en is high: y <= src(cur).
  - If mapped(sel) != cur: nxt <= mapped(sel), k <= 0, busy <= 1, state <= FADE. This happens on the same edge as the IDLE output update.
- FADE, on each sample_en:
  - k' = k+1.
  - y <= (src(cur)*(N-k') + src(nxt)*k') >> FADE_LOG2.
  - k <= k'.
  - When k' == N: y equals src(nxt) exactly, cur <= nxt, busy <= 0, state <= IDLE.
- sel changes during FADE are ignored. Select is level-sensitive: after returning to IDLE, the next cycle compares sel against cur again. A change made and reverted during a fade therefore causes no further fade.
- Arithmetic:
  - Unsigned.
  - Each product is WIDTH+FADE_LOG2+1 bits, and so is the sum.
  - Truncating shift.
  - The sum is ≤ (2**WIDTH-1)*N, so the result always fits WIDTH; no saturation is needed.
- sample_en low: y, k, cur and nxt hold. The IDLE→FADE entry still occurs.
- Taps are live values. Both source taps are re-read on every fade step.

## Timing
- Reset values: y=0, busy=0, cur=0, nxt=0, k=0, state=IDLE.
- Reset mid-fade aborts immediately. There is no residual fade after reset.
- IDLE latency: taps to y is 1 clk, on a sample_en edge.
- Select latency:
  - sel change to busy=1 is 1 clk.
  - The first blended sample appears on the first sample_en edge after busy rises.
  - The final (pure nxt) sample appears on the N-th such edge, coincident with busy falling.
- Full fade duration is exactly N sample_en-qualified cycles. It is never shorter and never skipped.
- Back-to-back fades: the earliest next fade entry is the clk after busy falls.

## Structure
- Shared package tap_crossfader_pkg:
  - state enum {IDLE, FADE}.
  - MUTE code derivation: localparam MUTE_CODE = NTAPS.
  - mapped-select function.
- Sub-module crossfade_mix:
  - Purely combinational.
  - Inputs: a, b, k.
  - Output: (a*(N-k)+b*k)>>FADE_LOG2.
  - Parameterised on WIDTH and FADE_LOG2.
- Top level holds the FSM, registers and tap extraction.

## Test plan
Common setup: taps = {0xFF, 0xC0, 0x80, 0x40} (tap3..tap0), defaults N=8.
- Reset: assert rst for 2 clk with sel=1, sample_en=1 → y=0 and busy=0 during reset. After release, busy rises 1 clk later and the fade from 0x40 toward 0x80 starts.
- Fade 0→1: with sample_en=1 constant, sel 0→1 → y = 0x48, 0x50, 0x58, 0x60, 0x68, 0x70, 0x78, 0x80 on consecutive edges. busy is high for exactly 8 clk, then y holds 0x80.
- Mute: from IDLE on tap3, set sel=0x07 → y = 0xDF, 0xBF, 0x9F, 0x7F, 0x5F, 0x3F, 0x1F, 0x00. Then changing sel=0x55 causes no fade (busy stays 0).
- Gated strobe: run the fade 0→2 with sample_en high every 3rd clk → y steps 0x50, 0x60, …, 0xC0 only on strobe edges. busy lasts 24 clk.
- Sel during fade: start 0→1, then at step 3 set sel=3 → the fade completes at 0x80. One clk after busy falls, busy rises again and the fade proceeds 0x80→0xFF (first step 0x8F). Separately, toggling sel to 3 and back to 1 mid-fade yields no second fade.
- Reset mid-fade: assert rst at step 4 of the fade 0→3 → next clk y=0, busy=0, cur=0. With sel=0 after release, y=0x40 and no fade occurs.
